ram_access_arbiter: RTL

Sequencing controller and two-port arbiter for the 256-byte, byte-addressed RAM (Enable/ReadWrite/Address/DataIn/Mode/moc interface). It shares the RAM between an instruction-fetch port (word reads) and a data port (byte/halfword/word/doubleword reads and writes). It produces clean Enable pulses with set-up and release phases and synchronizes the asynchronous moc handshake. Doubleword transfers are split into two word accesses, and an access that never completes is aborted with an error.

---
 rtl/ram_access_arbiter.sv | 192 +++++++++++++++++++
 1 files changed

// File: rtl/ram_access_arbiter.sv
`default_nettype none
// ============================================================================
// Module   : ram_access_arbiter
// Brief    : Two-port (fetch/data) arbiter and Enable/moc sequencer for the
//            256-byte byte-addressed RAM; splits doublewords, aborts on timeout.
// Revision : 1.0 - initial release
// ============================================================================
module ram_access_arbiter #(
  parameter int TIMEOUT = 16
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        if_req,
  input  logic [7:0]  if_addr,
  output logic        if_ack,
  output logic [31:0] if_rdata,
  input  logic        d_req,
  input  logic        d_rw,
  input  logic [1:0]  d_mode,
  input  logic [7:0]  d_addr,
  input  logic [63:0] d_wdata,
  output logic        d_ack,
  output logic        d_err,
  output logic [63:0] d_rdata,
  output logic        ram_enable,
  output logic        ram_readwrite,
  output logic [7:0]  ram_address,
  output logic [1:0]  ram_mode,
  output logic [31:0] ram_datain,
  input  logic [31:0] ram_dataout,
  input  logic        ram_moc
);

  localparam int c_CNT_W = $clog2(TIMEOUT + 1);

  typedef enum logic [2:0] {
    S_IDLE    = 3'd0,
    S_SETUP   = 3'd1,
    S_ACCESS  = 3'd2,
    S_RELEASE = 3'd3,
    S_DONE    = 3'd4,
    S_ERROR   = 3'd5
  } state_t;

  state_t               r_state;
  state_t               w_next;
  logic                 r_moc_meta;
  logic                 r_moc_s;
  logic [c_CNT_W-1:0]   r_cnt;
  logic                 r_last_data;   // 1 = data port granted last
  logic                 r_port_data;   // 1 = data port owns current transaction
  logic                 r_rw;
  logic                 r_double;
  logic                 r_second;
  logic [7:0]           r_addr;
  logic [31:0]          r_wdata_lo;
  logic [63:0]          r_buf;

  logic                 w_grant_data;
  logic                 w_timeout;
  logic                 w_load;
  logic                 w_half2;
  logic                 w_capture;

  always_comb begin
    w_next       = r_state;
    w_grant_data = d_req && (!if_req || !r_last_data);
    w_timeout    = (r_cnt == c_CNT_W'(TIMEOUT - 1));
    w_load       = 1'b0;
    w_half2      = 1'b0;
    w_capture    = 1'b0;
    case (r_state)
      S_IDLE: begin
        if (d_req || if_req) begin
          w_load = 1'b1;
          w_next = S_SETUP;
        end
      end
      S_SETUP: w_next = S_ACCESS;
      S_ACCESS: begin
        if (r_moc_s) begin
          w_capture = r_rw;
          w_next    = S_RELEASE;
        end else if (w_timeout) begin
          w_next = S_ERROR;
        end
      end
      S_RELEASE: begin
        if (!r_moc_s) begin
          if (r_double && !r_second) begin
            w_half2 = 1'b1;
            w_next  = S_SETUP;
          end else begin
            w_next = S_DONE;
          end
        end else if (w_timeout) begin
          w_next = S_ERROR;
        end
      end
      S_DONE:  w_next = S_IDLE;
      S_ERROR: w_next = S_IDLE;
      default: w_next = S_IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) r_state <= S_IDLE;
    else       r_state <= w_next;
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_moc_meta    <= 1'b0;
      r_moc_s       <= 1'b0;
      r_cnt         <= '0;
      r_last_data   <= 1'b0;
      r_port_data   <= 1'b0;
      r_rw          <= 1'b1;
      r_double      <= 1'b0;
      r_second      <= 1'b0;
      r_addr        <= 8'd0;
      r_wdata_lo    <= 32'd0;
      r_buf         <= 64'd0;
      ram_enable    <= 1'b0;
      ram_readwrite <= 1'b1;
      ram_address   <= 8'd0;
      ram_mode      <= 2'b00;
      ram_datain    <= 32'd0;
      if_ack        <= 1'b0;
      d_ack         <= 1'b0;
      d_err         <= 1'b0;
      if_rdata      <= 32'd0;
      d_rdata       <= 64'd0;
    end else begin
      r_moc_meta <= ram_moc;
      r_moc_s    <= r_moc_meta;

      if (r_state != w_next)
        r_cnt <= '0;
      else if (r_state == S_ACCESS || r_state == S_RELEASE)
        r_cnt <= r_cnt + 1'b1;

      if (w_load) begin
        r_port_data <= w_grant_data;
        r_last_data <= w_grant_data;
        r_second    <= 1'b0;
        if (w_grant_data) begin
          r_rw          <= d_rw;
          r_double      <= (d_mode == 2'b11);
          r_addr        <= d_addr;
          r_wdata_lo    <= d_wdata[31:0];
          ram_readwrite <= d_rw;
          ram_address   <= d_addr;
          ram_mode      <= (d_mode == 2'b11) ? 2'b10 : d_mode;
          ram_datain    <= (d_mode == 2'b11) ? d_wdata[63:32] : d_wdata[31:0];
        end else begin
          r_rw          <= 1'b1;
          r_double      <= 1'b0;
          r_addr        <= if_addr;
          ram_readwrite <= 1'b1;
          ram_address   <= if_addr;
          ram_mode      <= 2'b10;
        end
      end

      if (w_half2) begin
        r_second    <= 1'b1;
        ram_address <= r_addr + 8'd4;
        ram_datain  <= r_wdata_lo;
      end

      // Doubleword: first access lands in the upper word, second in the lower.
      if (w_capture) begin
        if (r_second)      r_buf[31:0]  <= ram_dataout;
        else if (r_double) r_buf[63:32] <= ram_dataout;
        else               r_buf        <= {32'd0, ram_dataout};
      end

      if (w_next == S_DONE && r_rw) begin
        if (r_port_data) d_rdata  <= r_buf;
        else             if_rdata <= r_buf[31:0];
      end

      ram_enable <= (w_next == S_ACCESS);
      if_ack     <= (w_next == S_DONE || w_next == S_ERROR) && !r_port_data;
      d_ack      <= (w_next == S_DONE || w_next == S_ERROR) && r_port_data;
      d_err      <= (w_next == S_ERROR) && r_port_data;
    end
  end

endmodule
`default_nettype wire
